// File: rtl/axis_pkt_fifo.sv
// rtl/axis_pkt_fifo.sv - AXI-Stream FIFO with tlast, fill level, almost-full and flush
// Define AXIS_PKT_FIFO_STORE_FWD_EN for store-and-forward packet mode.
module axis_pkt_fifo #(
    parameter int TDATA_WIDTH  = 32,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = DEPTH - 2,
    localparam int CW          = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sif_tvalid,
    input  logic [TDATA_WIDTH-1:0] sif_tdata,
    input  logic                   sif_tlast,
    output logic                   sif_tready,
    output logic                   mif_tvalid,
    output logic [TDATA_WIDTH-1:0] mif_tdata,
    output logic                   mif_tlast,
    input  logic                   mif_tready,
    input  logic                   invalidate,
    output logic [CW-1:0]          count,
    output logic                   almost_full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_THRESH);

    logic [TDATA_WIDTH:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 not_empty;
    logic                 out_ok;

    // Non-power-of-two depths need an explicit wrap instead of masking.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == FULL_CNT);
    assign not_empty = (count != '0);

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
    logic [CW-1:0] pkt_cnt;

    // Hold output until a whole packet is stored; a full FIFO forwards anyway to avoid deadlock.
    assign out_ok = (pkt_cnt != '0) | full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else if (invalidate) begin
            pkt_cnt <= '0;
        end else begin
            case ({push & sif_tlast, pop & mif_tlast})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end
`else
    assign out_ok = 1'b1;
`endif

    // Ready depends on registered state only, so a pop never frees a slot in the same cycle.
    assign sif_tready  = ~full & ~invalidate;
    assign mif_tvalid  = not_empty & out_ok & ~invalidate;
    assign {mif_tlast, mif_tdata} = mem[rd_ptr];
    assign push        = sif_tvalid & sif_tready;
    assign pop         = mif_tvalid & mif_tready;
    assign almost_full = (count >= AF_CNT);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {sif_tlast, sif_tdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (invalidate) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (invalidate) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
